spi_peripheral: RTL and testbench

SPI_PERIPHERAL -- requirements
Module: spi_peripheral

---
 rtl/spi_pkg.sv | 12 +
 rtl/spi_if.sv | 29 ++
 rtl/spi_sync.sv | 33 +++
 rtl/spi_peripheral.sv | 141 ++++++++++++++
 tb/tb_spi_peripheral.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// Shared SPI definitions: controller/peripheral state encoding and default word geometry.
package spi_pkg;

   localparam int unsigned DATA_WIDTH_DEF = 8;
   localparam int unsigned CNT_WIDTH_DEF  = 4;

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } spi_state_e;

endpackage

// File: rtl/spi_if.sv
// SPI pin bundle plus the local word-transfer handshake of one SPI peripheral.
interface spi_if
   import spi_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) ();

   logic                  sck;
   logic                  cs_n;
   logic                  sdi;
   logic                  sdo;
   logic                  sdo_en;
   logic [DATA_WIDTH-1:0] tx_data;
   logic                  tx_ack;
   logic [DATA_WIDTH-1:0] rx_data;
   logic                  rx_valid;
   logic                  busy;

   modport slave (
      input  sck, cs_n, sdi, tx_data,
      output sdo, sdo_en, tx_ack, rx_data, rx_valid, busy
   );

   modport master (
      output sck, cs_n, sdi, tx_data,
      input  sdo, sdo_en, tx_ack, rx_data, rx_valid, busy
   );

endinterface

// File: rtl/spi_sync.sv
// Single-bit 2-flop synchronizer with a third stage for rise/fall pulse detection.
module spi_sync #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q,
   output logic rise_c,
   output logic fall_c
);

   logic s1;
   logic s2;
   logic s3;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1 <= RST_VAL;
         s2 <= RST_VAL;
         s3 <= RST_VAL;
      end else begin
         s1 <= d;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign q      = s2;
   assign rise_c = s2 & ~s3;
   assign fall_c = ~s2 & s3;

endmodule

// File: rtl/spi_peripheral.sv
// Mode-0 SPI peripheral: oversamples sck/cs_n/sdi in the clk domain, MSB-first words,
// back-to-back words within one chip-select frame.
module spi_peripheral
   import spi_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int unsigned CNT_WIDTH  = CNT_WIDTH_DEF
) (
   input logic clk,
   input logic rst,
   spi_if.slave bus
);

   localparam logic [CNT_WIDTH-1:0] LAST_BIT = CNT_WIDTH'(DATA_WIDTH - 1);

   logic sck_q, sck_rise_c, sck_fall_c;
   logic cs_q, cs_rise_c, cs_fall_c;
   logic sdi_q, sdi_rise_c, sdi_fall_c;

   spi_sync #(.RST_VAL(1'b0)) u_sync_sck (
      .clk(clk), .rst(rst), .d(bus.sck), .q(sck_q), .rise_c(sck_rise_c), .fall_c(sck_fall_c)
   );
   spi_sync #(.RST_VAL(1'b1)) u_sync_cs (
      .clk(clk), .rst(rst), .d(bus.cs_n), .q(cs_q), .rise_c(cs_rise_c), .fall_c(cs_fall_c)
   );
   spi_sync #(.RST_VAL(1'b0)) u_sync_sdi (
      .clk(clk), .rst(rst), .d(bus.sdi), .q(sdi_q), .rise_c(sdi_rise_c), .fall_c(sdi_fall_c)
   );

   logic unused_sync_c;
   assign unused_sync_c = ^{sck_q, sdi_rise_c, sdi_fall_c};

   spi_state_e            state;
   logic [DATA_WIDTH-1:0] tx_sr;
   logic [DATA_WIDTH-1:0] rx_sr;
   logic [CNT_WIDTH-1:0]  bit_cnt;
   logic                  word_done;
   logic [1:0]            settle;
   logic                  armed;
   logic                  sdo_q;
   logic                  sdo_en_q;
   logic                  tx_ack_q;
   logic [DATA_WIDTH-1:0] rx_data_q;
   logic                  rx_valid_q;
   logic                  busy_q;

   logic [DATA_WIDTH-1:0] tx_shift_c;
   logic [DATA_WIDTH-1:0] rx_shift_c;

   assign tx_shift_c = tx_sr << 1;
   assign rx_shift_c = (rx_sr << 1) | DATA_WIDTH'(sdi_q);

   // armed only once cs_n has been seen high from the pin itself, so a select held
   // low across reset (synchronizer preset to idle) cannot fake a falling edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         tx_sr      <= '0;
         rx_sr      <= '0;
         bit_cnt    <= '0;
         word_done  <= 1'b0;
         settle     <= 2'b00;
         armed      <= 1'b0;
         sdo_q      <= 1'b0;
         sdo_en_q   <= 1'b0;
         tx_ack_q   <= 1'b0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         tx_ack_q   <= 1'b0;
         rx_valid_q <= 1'b0;
         settle     <= {settle[0], 1'b1};
         if (settle[1] && cs_q) begin
            armed <= 1'b1;
         end

         case (state)
            IDLE: begin
               if (cs_fall_c && armed) begin
                  state     <= ACTIVE;
                  tx_sr     <= bus.tx_data;
                  tx_ack_q  <= 1'b1;
                  bit_cnt   <= '0;
                  word_done <= 1'b0;
                  sdo_q     <= bus.tx_data[DATA_WIDTH-1];
                  sdo_en_q  <= 1'b1;
                  busy_q    <= 1'b1;
               end
            end

            ACTIVE: begin
               if (sck_rise_c) begin
                  rx_sr <= rx_shift_c;
                  if (bit_cnt == LAST_BIT) begin
                     rx_data_q  <= rx_shift_c;
                     rx_valid_q <= 1'b1;
                     bit_cnt    <= '0;
                     word_done  <= 1'b1;
                  end else begin
                     bit_cnt <= bit_cnt + CNT_WIDTH'(1);
                  end
               end

               // first falling edge after a completed word starts the next word
               if (sck_fall_c) begin
                  if (word_done) begin
                     tx_sr     <= bus.tx_data;
                     tx_ack_q  <= 1'b1;
                     sdo_q     <= bus.tx_data[DATA_WIDTH-1];
                     word_done <= 1'b0;
                  end else begin
                     tx_sr <= tx_shift_c;
                     sdo_q <= tx_shift_c[DATA_WIDTH-1];
                  end
               end

               // a word completing on this same cycle still reports above
               if (cs_rise_c) begin
                  state     <= IDLE;
                  sdo_q     <= 1'b0;
                  sdo_en_q  <= 1'b0;
                  busy_q    <= 1'b0;
                  bit_cnt   <= '0;
                  word_done <= 1'b0;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

   assign bus.sdo      = sdo_q;
   assign bus.sdo_en   = sdo_en_q;
   assign bus.tx_ack   = tx_ack_q;
   assign bus.rx_data  = rx_data_q;
   assign bus.rx_valid = rx_valid_q;
   assign bus.busy     = busy_q;

endmodule

// File: tb/tb_spi_peripheral.sv
// Directed bench for spi_peripheral: acts as a mode-0 controller at clk/16.
module tb_spi_peripheral;

   localparam int unsigned W    = 8;
   localparam int unsigned HALF = 8;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   spi_if #(.DATA_WIDTH(W)) bus ();

   spi_peripheral #(.DATA_WIDTH(W), .CNT_WIDTH(4)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int errors = 0;
   int checks = 0;
   int rx_cnt = 0;
   int tx_cnt = 0;
   bit en_seen = 1'b0;
   logic [W-1:0] rx_log [0:31];

   // pulse monitor, sampled on the falling clk edge
   always @(negedge clk) begin
      if (bus.rx_valid === 1'b1) begin
         if (rx_cnt < 32) rx_log[rx_cnt] = bus.rx_data;
         rx_cnt++;
      end
      if (bus.tx_ack === 1'b1) tx_cnt++;
      if (bus.sdo_en === 1'b1) en_seen = 1'b1;
   end

   task automatic half_period();
      repeat (HALF) @(negedge clk);
   endtask

   // one MSB-first word; when last, sck is left high so cs_n can rise before it falls
   task automatic spi_word(input logic [W-1:0] mosi, input bit last, output logic [W-1:0] miso);
      for (int i = W - 1; i >= 0; i--) begin
         bus.sdi = mosi[i];
         half_period();
         miso[i] = bus.sdo;
         bus.sck = 1'b1;
         half_period();
         if (!(last && i == 0)) bus.sck = 1'b0;
      end
   endtask

   task automatic end_frame();
      bus.cs_n = 1'b1;
      half_period();
      bus.sck = 1'b0;
      half_period();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.sck = 1'b0;
      bus.cs_n = 1'b1;
      bus.sdi = 1'b0;
      bus.tx_data = '0;
      repeat (3) @(negedge clk);
      checks++; if (bus.sdo !== 1'b0) begin errors++; $display("FAIL reset_sdo: got %b want 0", bus.sdo); end
      checks++; if (bus.sdo_en !== 1'b0) begin errors++; $display("FAIL reset_sdo_en: got %b want 0", bus.sdo_en); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
      checks++; if (bus.rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %b want 0", bus.rx_valid); end
      checks++; if (bus.tx_ack !== 1'b0) begin errors++; $display("FAIL reset_tx_ack: got %b want 0", bus.tx_ack); end
      checks++; if (bus.rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %h want 00", bus.rx_data); end
      rst = 1'b0;
      half_period();
   endtask

   task automatic test_single_word();
      int r0, t0;
      logic [W-1:0] miso;
      r0 = rx_cnt;
      t0 = tx_cnt;
      bus.tx_data = 8'hA5;
      @(negedge clk);
      bus.cs_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (bus.sdo_en !== 1'b1) begin errors++; $display("FAIL single_sdo_en_latency: got %b want 1", bus.sdo_en); end
      checks++; if (bus.sdo !== 1'b1) begin errors++; $display("FAIL single_sdo_first_bit: got %b want 1", bus.sdo); end
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", bus.busy); end
      @(negedge clk);
      spi_word(8'h3C, 1'b1, miso);
      end_frame();
      checks++; if (rx_cnt - r0 !== 1) begin errors++; $display("FAIL single_rx_valid_count: got %0d want 1", rx_cnt - r0); end
      checks++; if (rx_log[r0] !== 8'h3C) begin errors++; $display("FAIL single_rx_word: got %h want 3c", rx_log[r0]); end
      checks++; if (bus.rx_data !== 8'h3C) begin errors++; $display("FAIL single_rx_data_held: got %h want 3c", bus.rx_data); end
      checks++; if (miso !== 8'hA5) begin errors++; $display("FAIL single_miso: got %h want a5", miso); end
      checks++; if (tx_cnt - t0 !== 1) begin errors++; $display("FAIL single_tx_ack_count: got %0d want 1", tx_cnt - t0); end
      checks++; if (bus.sdo_en !== 1'b0) begin errors++; $display("FAIL single_sdo_en_after: got %b want 0", bus.sdo_en); end
   endtask

   task automatic test_back_to_back();
      int r0, t0;
      logic [W-1:0] m0, m1;
      r0 = rx_cnt;
      t0 = tx_cnt;
      bus.tx_data = 8'h81;
      @(negedge clk);
      bus.cs_n = 1'b0;
      half_period();
      bus.tx_data = 8'h7E;
      spi_word(8'hF0, 1'b0, m0);
      spi_word(8'h0F, 1'b1, m1);
      end_frame();
      checks++; if (rx_cnt - r0 !== 2) begin errors++; $display("FAIL b2b_rx_valid_count: got %0d want 2", rx_cnt - r0); end
      checks++; if (rx_log[r0] !== 8'hF0) begin errors++; $display("FAIL b2b_rx_word0: got %h want f0", rx_log[r0]); end
      checks++; if (rx_log[r0+1] !== 8'h0F) begin errors++; $display("FAIL b2b_rx_word1: got %h want 0f", rx_log[r0+1]); end
      checks++; if (m0 !== 8'h81) begin errors++; $display("FAIL b2b_miso0: got %h want 81", m0); end
      checks++; if (m1 !== 8'h7E) begin errors++; $display("FAIL b2b_miso1: got %h want 7e", m1); end
      checks++; if (tx_cnt - t0 !== 2) begin errors++; $display("FAIL b2b_tx_ack_count: got %0d want 2", tx_cnt - t0); end
   endtask

   task automatic test_abort();
      int r0;
      logic [W-1:0] miso;
      r0 = rx_cnt;
      bus.tx_data = 8'h33;
      @(negedge clk);
      bus.cs_n = 1'b0;
      half_period();
      for (int i = 0; i < 5; i++) begin
         bus.sdi = 1'b1;
         half_period();
         bus.sck = 1'b1;
         half_period();
         bus.sck = 1'b0;
      end
      @(negedge clk);
      bus.cs_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (bus.sdo_en !== 1'b0) begin errors++; $display("FAIL abort_sdo_en: got %b want 0", bus.sdo_en); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", bus.busy); end
      checks++; if (bus.sdo !== 1'b0) begin errors++; $display("FAIL abort_sdo: got %b want 0", bus.sdo); end
      half_period();
      checks++; if (rx_cnt - r0 !== 0) begin errors++; $display("FAIL abort_rx_valid_count: got %0d want 0", rx_cnt - r0); end
      checks++; if (bus.rx_data !== 8'h0F) begin errors++; $display("FAIL abort_rx_data_kept: got %h want 0f", bus.rx_data); end
      // a full frame right after the abort must start from bit 0
      bus.tx_data = 8'h5A;
      @(negedge clk);
      bus.cs_n = 1'b0;
      spi_word(8'hC6, 1'b1, miso);
      end_frame();
      checks++; if (bus.rx_data !== 8'hC6) begin errors++; $display("FAIL post_abort_rx: got %h want c6", bus.rx_data); end
      checks++; if (miso !== 8'h5A) begin errors++; $display("FAIL post_abort_miso: got %h want 5a", miso); end
   endtask

   task automatic test_idle_sck();
      int r0, t0;
      r0 = rx_cnt;
      t0 = tx_cnt;
      en_seen = 1'b0;
      bus.cs_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         bus.sdi = i[0];
         half_period();
         bus.sck = 1'b1;
         half_period();
         bus.sck = 1'b0;
      end
      half_period();
      checks++; if (rx_cnt - r0 !== 0) begin errors++; $display("FAIL idle_rx_valid: got %0d want 0", rx_cnt - r0); end
      checks++; if (tx_cnt - t0 !== 0) begin errors++; $display("FAIL idle_tx_ack: got %0d want 0", tx_cnt - t0); end
      checks++; if (en_seen !== 1'b0) begin errors++; $display("FAIL idle_sdo_en_seen: got %b want 0", en_seen); end
   endtask

   task automatic test_reset_mid_frame();
      int r0, t0;
      logic [W-1:0] miso;
      bus.tx_data = 8'hC3;
      @(negedge clk);
      bus.cs_n = 1'b0;
      half_period();
      for (int i = 0; i < 3; i++) begin
         bus.sdi = 1'b1;
         half_period();
         bus.sck = 1'b1;
         half_period();
         bus.sck = 1'b0;
      end
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (bus.sdo_en !== 1'b0) begin errors++; $display("FAIL rstmid_sdo_en: got %b want 0", bus.sdo_en); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", bus.busy); end
      checks++; if (bus.sdo !== 1'b0) begin errors++; $display("FAIL rstmid_sdo: got %b want 0", bus.sdo); end
      checks++; if (bus.rx_data !== 8'h00) begin errors++; $display("FAIL rstmid_rx_data: got %h want 00", bus.rx_data); end
      rst = 1'b0;
      t0 = tx_cnt;
      en_seen = 1'b0;
      repeat (20) @(negedge clk);
      checks++; if (en_seen !== 1'b0) begin errors++; $display("FAIL rstmid_no_restart_en: got %b want 0", en_seen); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_no_restart_busy: got %b want 0", bus.busy); end
      checks++; if (tx_cnt - t0 !== 0) begin errors++; $display("FAIL rstmid_no_restart_ack: got %0d want 0", tx_cnt - t0); end
      bus.cs_n = 1'b1;
      half_period();
      r0 = rx_cnt;
      @(negedge clk);
      bus.cs_n = 1'b0;
      spi_word(8'h55, 1'b1, miso);
      end_frame();
      checks++; if (rx_cnt - r0 !== 1) begin errors++; $display("FAIL rstmid_new_rx_count: got %0d want 1", rx_cnt - r0); end
      checks++; if (bus.rx_data !== 8'h55) begin errors++; $display("FAIL rstmid_new_rx_data: got %h want 55", bus.rx_data); end
      checks++; if (miso !== 8'hC3) begin errors++; $display("FAIL rstmid_new_miso: got %h want c3", miso); end
      checks++; if (tx_cnt - t0 !== 1) begin errors++; $display("FAIL rstmid_new_tx_ack: got %0d want 1", tx_cnt - t0); end
   endtask

   initial begin
      test_reset();
      test_single_word();
      test_back_to_back();
      test_abort();
      test_idle_sck();
      test_reset_mid_frame();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
